// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI write-path arbiter: round-robin AW grant into a registered slice,
// W bursts steered in AW-grant order by a small order FIFO, B routed by ID prefix.
//
// state | meaning (AW slice, encoded by m_aw_valid)
// EMPTY | m_aw_valid=0, slice free, may load a grant every cycle
// HOLD  | m_aw_valid=1, waiting for m_aw_ready; id/payload frozen
module axi_wr_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 4,
    parameter int AWP_W        = 64,
    parameter int WD_W         = 73,
    parameter int BP_W         = 3,
    parameter int W_FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   s_aw_valid,
    output logic [N_REQ-1:0]                   s_aw_ready,
    input  logic [N_REQ*ID_W-1:0]              s_aw_id,
    input  logic [N_REQ*AWP_W-1:0]             s_aw_payload,
    input  logic [N_REQ-1:0]                   s_w_valid,
    output logic [N_REQ-1:0]                   s_w_ready,
    input  logic [N_REQ*WD_W-1:0]              s_w_payload,
    input  logic [N_REQ-1:0]                   s_w_last,
    output logic [N_REQ-1:0]                   s_b_valid,
    input  logic [N_REQ-1:0]                   s_b_ready,
    output logic [ID_W-1:0]                    s_b_id,
    output logic [BP_W-1:0]                    s_b_payload,
    output logic                               m_aw_valid,
    input  logic                               m_aw_ready,
    output logic [ID_W+$clog2(N_REQ)-1:0]      m_aw_id,
    output logic [AWP_W-1:0]                   m_aw_payload,
    output logic                               m_w_valid,
    input  logic                               m_w_ready,
    output logic [WD_W-1:0]                    m_w_payload,
    output logic                               m_w_last,
    input  logic                               m_b_valid,
    output logic                               m_b_ready,
    input  logic [ID_W+$clog2(N_REQ)-1:0]      m_b_id,
    input  logic [BP_W-1:0]                    m_b_payload
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int FP_W  = $clog2(W_FIFO_DEPTH);

    logic [IDX_W-1:0] rr_ptr;
    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    logic [ID_W-1:0]  gnt_id;
    logic [AWP_W-1:0] gnt_payload;
    logic             load_en;
    logic             aw_take;

    logic [IDX_W-1:0] fifo_mem [W_FIFO_DEPTH];
    logic [FP_W-1:0]  wr_ptr;
    logic [FP_W-1:0]  rd_ptr;
    logic [FP_W:0]    fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] head;
    logic             w_pop;
    logic [IDX_W-1:0] b_idx;

    // Two passes give the wrapped search: requesters at/above the pointer first, then the rest.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && s_aw_valid[i] && (IDX_W'(i) >= rr_ptr)) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && s_aw_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        gnt_id      = '0;
        gnt_payload = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == gnt_idx) begin
                gnt_id      = s_aw_id[i*ID_W +: ID_W];
                gnt_payload = s_aw_payload[i*AWP_W +: AWP_W];
            end
        end
    end

    assign fifo_full  = (fifo_cnt == (FP_W+1)'(W_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign load_en    = (!m_aw_valid || m_aw_ready) && !fifo_full;
    assign aw_take    = load_en && gnt_found;

    always_comb begin
        s_aw_ready = '0;
        if (rst_n && aw_take)
            s_aw_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_aw_valid   <= 1'b0;
            m_aw_id      <= '0;
            m_aw_payload <= '0;
            rr_ptr       <= '0;
        end else if (load_en) begin
            if (gnt_found) begin
                m_aw_valid   <= 1'b1;
                m_aw_id      <= {gnt_idx, gnt_id};
                m_aw_payload <= gnt_payload;
                rr_ptr       <= (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
            end else begin
                m_aw_valid <= 1'b0;
            end
        end
    end

    // Order FIFO storage needs no reset; the count alone defines validity.
    always_ff @(posedge clk) begin
        if (aw_take)
            fifo_mem[wr_ptr] <= gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (aw_take)
                wr_ptr <= wr_ptr + FP_W'(1);
            if (w_pop)
                rd_ptr <= rd_ptr + FP_W'(1);
            case ({aw_take, w_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FP_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FP_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head = fifo_mem[rd_ptr];

    always_comb begin
        m_w_valid   = 1'b0;
        m_w_payload = '0;
        m_w_last    = 1'b0;
        s_w_ready   = '0;
        if (rst_n && !fifo_empty) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (IDX_W'(i) == head) begin
                    m_w_valid    = s_w_valid[i];
                    m_w_payload  = s_w_payload[i*WD_W +: WD_W];
                    m_w_last     = s_w_last[i];
                    s_w_ready[i] = m_w_ready;
                end
            end
        end
    end

    assign w_pop = m_w_valid && m_w_ready && m_w_last;

    // Responses whose prefix names no requester are sunk so the slave never stalls.
    assign b_idx = m_b_id[ID_W +: IDX_W];

    always_comb begin
        s_b_valid = '0;
        m_b_ready = rst_n;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == b_idx) begin
                s_b_valid[i] = rst_n && m_b_valid;
                m_b_ready    = rst_n && s_b_ready[i];
            end
        end
    end

    assign s_b_id      = m_b_id[ID_W-1:0];
    assign s_b_payload = m_b_payload;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axi_wr_arbiter;
    localparam int N_REQ = 3;
    localparam int ID_W  = 4;
    localparam int AWP_W = 64;
    localparam int WD_W  = 73;
    localparam int BP_W  = 3;
    localparam int DEPTH = 2;
    localparam int IDX_W = $clog2(N_REQ);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        s_aw_valid, s_aw_ready;
    logic [N_REQ*ID_W-1:0]   s_aw_id;
    logic [N_REQ*AWP_W-1:0]  s_aw_payload;
    logic [N_REQ-1:0]        s_w_valid, s_w_ready, s_w_last;
    logic [N_REQ*WD_W-1:0]   s_w_payload;
    logic [N_REQ-1:0]        s_b_valid, s_b_ready;
    logic [ID_W-1:0]         s_b_id;
    logic [BP_W-1:0]         s_b_payload;
    logic                    m_aw_valid, m_aw_ready;
    logic [ID_W+IDX_W-1:0]   m_aw_id;
    logic [AWP_W-1:0]        m_aw_payload;
    logic                    m_w_valid, m_w_ready, m_w_last;
    logic [WD_W-1:0]         m_w_payload;
    logic                    m_b_valid, m_b_ready;
    logic [ID_W+IDX_W-1:0]   m_b_id;
    logic [BP_W-1:0]         m_b_payload;

    int n_assert = 0;
    int n_fail   = 0;
    int acc_q[$];

    axi_wr_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .AWP_W(AWP_W), .WD_W(WD_W), .BP_W(BP_W),
        .W_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
        .s_aw_payload(s_aw_payload),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_payload(s_w_payload),
        .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id),
        .s_b_payload(s_b_payload),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id),
        .m_aw_payload(m_aw_payload),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_payload(m_w_payload),
        .m_w_last(m_w_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id),
        .m_b_payload(m_b_payload)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_aw(input int r, input logic [ID_W-1:0] id, input logic [AWP_W-1:0] pl);
        s_aw_id[r*ID_W +: ID_W]      = id;
        s_aw_payload[r*AWP_W +: AWP_W] = pl;
    endtask

    // Reference model: state as it stands after the most recent rising edge.
    int                    mdl_ptr;
    int                    mdl_fifo[$];
    logic                  mdl_v;
    logic [ID_W+IDX_W-1:0] mdl_id;
    logic [AWP_W-1:0]      mdl_pl;

    always @(negedge clk) begin : model
        logic [N_REQ-1:0] e_aw_rdy, e_w_rdy, e_b_v;
        logic             e_w_v, e_w_last, e_b_rdy, load;
        logic [WD_W-1:0]  e_w_pl;
        int               g, h, k, c;
        if (!rst_n) begin
            mdl_ptr = 0;
            mdl_fifo.delete();
            mdl_v  = 1'b0;
            mdl_id = '0;
            mdl_pl = '0;
        end
        e_aw_rdy = '0; e_w_rdy = '0; e_b_v = '0;
        e_w_v = 1'b0; e_w_last = 1'b0; e_b_rdy = 1'b0; e_w_pl = '0;
        load = 1'b0; g = -1; h = -1;
        if (rst_n) begin
            load = (!mdl_v || m_aw_ready) && (mdl_fifo.size() < DEPTH);
            if (load) begin
                for (int i = 0; i < N_REQ; i++) begin
                    c = (mdl_ptr + i) % N_REQ;
                    if (g < 0 && s_aw_valid[c]) g = c;
                end
            end
            if (g >= 0) e_aw_rdy[g] = 1'b1;
            if (mdl_fifo.size() > 0) begin
                h = mdl_fifo[0];
                e_w_v      = s_w_valid[h];
                e_w_pl     = s_w_payload[h*WD_W +: WD_W];
                e_w_last   = s_w_last[h];
                e_w_rdy[h] = m_w_ready;
            end
            k = int'(m_b_id) / (1 << ID_W);
            if (k < N_REQ) begin
                e_b_v[k] = m_b_valid;
                e_b_rdy  = s_b_ready[k];
            end else begin
                e_b_rdy = 1'b1;
            end
        end
        chk("s_aw_ready", s_aw_ready, e_aw_rdy);
        chk("m_aw_valid", m_aw_valid, mdl_v);
        chk("m_aw_id", m_aw_id, mdl_id);
        chk("m_aw_payload", m_aw_payload, mdl_pl);
        chk("m_w_valid", m_w_valid, e_w_v);
        chk("s_w_ready", s_w_ready, e_w_rdy);
        chk("s_b_valid", s_b_valid, e_b_v);
        chk("m_b_ready", m_b_ready, e_b_rdy);
        chk("s_b_id", s_b_id, m_b_id[ID_W-1:0]);
        chk("s_b_payload", s_b_payload, m_b_payload);
        if (h >= 0) begin
            chk("m_w_payload", m_w_payload, e_w_pl);
            chk("m_w_last", m_w_last, e_w_last);
        end
        if (rst_n) begin
            if (e_w_v && m_w_ready && e_w_last) void'(mdl_fifo.pop_front());
            if (g >= 0) begin
                mdl_fifo.push_back(g);
                mdl_v   = 1'b1;
                mdl_id  = {IDX_W'(g), s_aw_id[g*ID_W +: ID_W]};
                mdl_pl  = s_aw_payload[g*AWP_W +: AWP_W];
                mdl_ptr = (g + 1) % N_REQ;
            end else if (load) begin
                mdl_v = 1'b0;
            end
        end
    end

    // Presents a burst of 'beats' on every requester in mask; records accepted beats in order.
    task automatic run_w(input logic [N_REQ-1:0] mask, input int beats);
        int               cnt [N_REQ];
        logic [N_REQ-1:0] pend, acc;
        int               cyc;
        pend = mask;
        cyc  = 0;
        foreach (cnt[r]) cnt[r] = 0;
        while (pend != '0 && cyc < 200) begin
            for (int r = 0; r < N_REQ; r++) begin
                s_w_valid[r] = pend[r];
                s_w_payload[r*WD_W +: WD_W] = WD_W'(r*256 + cnt[r] + 17);
                s_w_last[r] = (cnt[r] == beats - 1);
            end
            neg();
            acc = s_w_ready & s_w_valid & {N_REQ{m_w_ready}};
            for (int r = 0; r < N_REQ; r++) begin
                if (acc[r]) begin
                    acc_q.push_back(r);
                    cnt[r]++;
                    if (cnt[r] == beats) pend[r] = 1'b0;
                end
            end
            step();
            cyc++;
        end
        s_w_valid = '0;
        s_w_last  = '0;
        chk("w_burst_timeout", pend, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_aw_valid = '0; s_aw_id = '0; s_aw_payload = '0;
        s_w_valid = '0; s_w_payload = '0; s_w_last = '0;
        s_b_ready = '0;
        m_aw_ready = 1'b1; m_w_ready = 1'b1;
        m_b_valid = 1'b0; m_b_id = '0; m_b_payload = '0;

        neg();
        chk("rst_m_aw_valid", m_aw_valid, 1'b0);
        chk("rst_m_aw_id", m_aw_id, '0);
        chk("rst_m_b_ready", m_b_ready, 1'b0);
        step();
        rst_n = 1'b1;

        // T1: req0 and req2 together, pointer at 0
        set_aw(0, 4'hA, 64'hA0A0);
        set_aw(2, 4'h3, 64'h3030);
        s_aw_valid = 3'b101;
        neg();
        chk("t1_rdy0", s_aw_ready, 3'b001);
        step();
        s_aw_valid = 3'b100;
        neg();
        chk("t1_id0", m_aw_id, 6'h0A);
        chk("t1_pl0", m_aw_payload, 64'hA0A0);
        chk("t1_rdy2", s_aw_ready, 3'b100);
        step();
        s_aw_valid = '0;
        neg();
        chk("t1_id2", m_aw_id, 6'h23);
        step();
        run_w(3'b101, 1);

        // T2: req1 then req0 granted; both bursts offered together
        acc_q.delete();
        set_aw(1, 4'h1, 64'h1111);
        s_aw_valid = 3'b010;
        neg();
        chk("t2_rdy1", s_aw_ready, 3'b010);
        step();
        set_aw(0, 4'h2, 64'h2222);
        s_aw_valid = 3'b001;
        neg();
        chk("t2_rdy0", s_aw_ready, 3'b001);
        step();
        s_aw_valid = '0;
        run_w(3'b011, 4);
        chk("t2_beats", acc_q.size(), 8);
        for (int i = 0; i < acc_q.size() && i < 8; i++)
            chk("t2_order", acc_q[i], (i < 4) ? 1 : 0);

        // T3: order FIFO full blocks the third AW until a burst completes
        set_aw(0, 4'h4, 64'h4444);
        set_aw(1, 4'h5, 64'h5555);
        set_aw(2, 4'h6, 64'h6666);
        s_aw_valid = 3'b111;
        neg();
        chk("t3_rdy1", s_aw_ready, 3'b010);
        step();
        s_aw_valid = 3'b101;
        neg();
        chk("t3_rdy2", s_aw_ready, 3'b100);
        step();
        s_aw_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("t3_blocked", s_aw_ready, 3'b000);
            step();
        end
        s_w_valid = 3'b010;
        s_w_last  = 3'b010;
        neg();
        chk("t3_w_rdy1", s_w_ready, 3'b010);
        chk("t3_still_blocked", s_aw_ready, 3'b000);
        step();
        s_w_valid = '0;
        s_w_last  = '0;
        neg();
        chk("t3_rdy0", s_aw_ready, 3'b001);
        step();
        s_aw_valid = '0;
        run_w(3'b101, 1);

        // T4: downstream AW stall holds the slice
        m_aw_ready = 1'b0;
        set_aw(1, 4'hC, 64'hCCCC);
        s_aw_valid = 3'b010;
        neg();
        chk("t4_rdy1", s_aw_ready, 3'b010);
        step();
        set_aw(2, 4'h9, 64'h9999);
        s_aw_valid = 3'b100;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("t4_hold_v", m_aw_valid, 1'b1);
            chk("t4_hold_id", m_aw_id, 6'h1C);
            chk("t4_hold_pl", m_aw_payload, 64'hCCCC);
            chk("t4_hold_rdy", s_aw_ready, 3'b000);
            step();
        end
        m_aw_ready = 1'b1;
        neg();
        chk("t4_rdy2", s_aw_ready, 3'b100);
        step();
        s_aw_valid = '0;
        neg();
        chk("t4_id2", m_aw_id, 6'h29);
        step();
        run_w(3'b110, 1);

        // T5: B routing by prefix, including an out-of-range prefix
        m_b_valid = 1'b1;
        m_b_id = 6'h25;
        m_b_payload = 3'b101;
        s_b_ready = '0;
        for (int i = 0; i < 2; i++) begin
            neg();
            chk("t5_b_valid", s_b_valid, 3'b100);
            chk("t5_b_id", s_b_id, 4'h5);
            chk("t5_b_ready_low", m_b_ready, 1'b0);
            step();
        end
        s_b_ready = 3'b100;
        neg();
        chk("t5_b_ready_high", m_b_ready, 1'b1);
        step();
        m_b_id = 6'h37;
        s_b_ready = '0;
        neg();
        chk("t5_sink_ready", m_b_ready, 1'b1);
        chk("t5_sink_valid", s_b_valid, 3'b000);
        step();
        m_b_valid = 1'b0;
        m_b_id = '0;

        // T6: reset in the middle of a burst, AW still held downstream
        m_aw_ready = 1'b0;
        set_aw(0, 4'h6, 64'h6060);
        s_aw_valid = 3'b001;
        neg();
        chk("t6_rdy0", s_aw_ready, 3'b001);
        step();
        s_aw_valid = '0;
        for (int b = 0; b < 3; b++) begin
            s_w_valid = 3'b001;
            s_w_payload[0 +: WD_W] = WD_W'(b + 100);
            neg();
            chk("t6_beat_rdy", s_w_ready, 3'b001);
            step();
        end
        rst_n = 1'b0;
        neg();
        chk("t6_rst_aw_v", m_aw_valid, 1'b0);
        chk("t6_rst_w_v", m_w_valid, 1'b0);
        chk("t6_rst_w_rdy", s_w_ready, 3'b000);
        step();
        rst_n = 1'b1;
        m_aw_ready = 1'b1;
        neg();
        chk("t6_fifo_empty", m_w_valid, 1'b0);
        step();
        s_w_valid = '0;
        set_aw(1, 4'h7, 64'h7070);
        set_aw(2, 4'h8, 64'h8080);
        s_aw_valid = 3'b111;
        neg();
        chk("t6_first_grant", s_aw_ready, 3'b001);
        step();
        s_aw_valid = '0;
        neg();
        chk("t6_id0", m_aw_id, 6'h06);
        step();
        run_w(3'b001, 1);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
